// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants and the zigzag-to-raster index table.
// Used by zigzag_buffer in both the forward and the ZZ_INVERSE_EN build.
package jpeg_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int BLK_N      = 64;
   localparam int IDX_W      = 6;
   localparam int MEM_AW     = IDX_W + 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } zz_state_e;

   // Entry k is the raster position of the k-th coefficient in zigzag order.
   localparam logic [IDX_W-1:0] ZZ_LUT [BLK_N] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic [IDX_W-1:0] zz_idx(input logic [IDX_W-1:0] k);
      return ZZ_LUT[k];
   endfunction

endpackage

// File: rtl/buf_mem.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Only the read data register is reset; the array contents are not.
module buf_mem #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 7
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read data holds when no read is issued, so a stalled stream keeps its last value.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 reorder buffer: row-major in, zigzag out (raster out when
// ZZ_INVERSE_EN is defined). Input and output advance together on ena_in.
//
//   state     | meaning
//   ST_IDLE   | first block still filling, reads suppressed
//   ST_STREAM | one full block buffered, a read issues on every ena_in
module zigzag_buffer
   import jpeg_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic              ena_in,
   input  logic [DATA_W-1:0] S_in,
   output logic [DATA_W-1:0] S_out,
   output logic              valid_out,
   output logic              sob_out
);

   zz_state_e         state_q;
   zz_state_e         state_d;
   logic [IDX_W-1:0]  widx;
   logic [IDX_W-1:0]  ridx;
   logic              wbuf;
   logic              primed;
   logic              rd_issue;
   logic [IDX_W-1:0]  lut_in;
   logic [IDX_W-1:0]  lut_out;
   logic [MEM_AW-1:0] wr_addr;
   logic [MEM_AW-1:0] rd_addr;

   assign primed   = (state_q == ST_STREAM);
   assign rd_issue = ena_in && primed;

   // A single LUT serves whichever side is permuted in this build.
`ifdef ZZ_INVERSE_EN
   assign lut_in  = widx;
   assign lut_out = zz_idx(lut_in);
   assign wr_addr = {wbuf, lut_out};
   assign rd_addr = {~wbuf, ridx};
`else
   assign lut_in  = ridx;
   assign lut_out = zz_idx(lut_in);
   assign wr_addr = {wbuf, widx};
   assign rd_addr = {~wbuf, lut_out};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ena_in && (widx == 6'd63)) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: state_d = ST_STREAM;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         widx      <= '0;
         ridx      <= '0;
         wbuf      <= 1'b0;
         valid_out <= 1'b0;
         sob_out   <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_out <= rd_issue;
         sob_out   <= rd_issue && (ridx == 6'd0);
         if (ena_in) begin
            widx <= widx + 6'd1;
            if (widx == 6'd63) begin
               wbuf <= ~wbuf;
            end
         end
         // Once primed, ridx tracks widx exactly, so both wrap on the same edge.
         if (rd_issue) begin
            ridx <= ridx + 6'd1;
         end
      end
   end

   buf_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (MEM_AW)
   ) u_buf_mem (
      .CLOCK_50 (CLOCK_50),
      .rst      (rst),
      .wr_en    (ena_in),
      .wr_addr  (wr_addr),
      .wr_data  (S_in),
      .rd_en    (rd_issue),
      .rd_addr  (rd_addr),
      .rd_data  (S_out)
   );

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed bench for zigzag_buffer; expected orders come from a local zigzag table.
// Define ZZ_INVERSE_EN to exercise the de-zigzag build with the same scenarios.
module tb_zigzag_buffer;

   localparam int DW = 12;

   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   logic          CLOCK_50 = 1'b0;
   logic          rst      = 1'b1;
   logic          ena_in   = 1'b0;
   logic [DW-1:0] S_in     = '0;
   logic [DW-1:0] S_out;
   logic          valid_out;
   logic          sob_out;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] obs_val [$];
   bit            obs_sob [$];
   int            stray = 0;
   bit            last_ena = 1'b0;

   always #5 CLOCK_50 = ~CLOCK_50;

   zigzag_buffer #(.DATA_W(DW)) dut (
      .CLOCK_50  (CLOCK_50),
      .rst       (rst),
      .ena_in    (ena_in),
      .S_in      (S_in),
      .S_out     (S_out),
      .valid_out (valid_out),
      .sob_out   (sob_out)
   );

   always @(posedge CLOCK_50) last_ena <= ena_in;

   always @(negedge CLOCK_50) begin
      if (valid_out === 1'b1) begin
         obs_val.push_back(S_out);
         obs_sob.push_back(sob_out);
         if (!last_ena) stray++;
      end
   end

   function automatic int in_val(int base, int i);
`ifdef ZZ_INVERSE_EN
      return base + ZZ[i];
`else
      return base + i;
`endif
   endfunction

   function automatic int exp_val(int base, int k);
`ifdef ZZ_INVERSE_EN
      return base + k;
`else
      return base + ZZ[k];
`endif
   endfunction

   task automatic cyc(input bit e, input int d);
      ena_in = e;
      S_in   = DW'(d);
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      rst = 1'b0;
      cyc(1'b0, 0);
      obs_val.delete();
      obs_sob.delete();
      stray = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 12'habc);
         total++;
         if (S_out !== '0) begin
            bad++; $display("FAIL reset_s_out cyc=%0d got=%h want=0", i, S_out);
         end
         total++;
         if (valid_out !== 1'b0) begin
            bad++; $display("FAIL reset_valid cyc=%0d got=%b want=0", i, valid_out);
         end
         total++;
         if (sob_out !== 1'b0) begin
            bad++; $display("FAIL reset_sob cyc=%0d got=%b want=0", i, sob_out);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      int nsob;
      do_reset();
      for (int i = 0; i < 128; i++) begin
         cyc(1'b1, (i < 64) ? in_val(0, i) : in_val(500, i - 64));
         if (i == 63) begin
            total++;
            if (valid_out !== 1'b0) begin
               bad++; $display("FAIL ramp_pre_valid got=%b want=0", valid_out);
            end
         end
         if (i == 64) begin
            total++;
            if (valid_out !== 1'b1 || sob_out !== 1'b1 || S_out !== DW'(exp_val(0, 0))) begin
               bad++;
               $display("FAIL ramp_first got v=%b s=%b d=%0d want v=1 s=1 d=%0d",
                        valid_out, sob_out, S_out, exp_val(0, 0));
            end
         end
      end
      cyc(1'b0, 77);
      total++;
      if (valid_out !== 1'b0) begin
         bad++; $display("FAIL ramp_stall_valid got=%b want=0", valid_out);
      end
      total++;
      if (S_out !== DW'(exp_val(0, 63))) begin
         bad++; $display("FAIL ramp_hold got=%0d want=%0d", S_out, exp_val(0, 63));
      end
      total++;
      if (obs_val.size() != 64) begin
         bad++; $display("FAIL ramp_count got=%0d want=64", obs_val.size());
      end else begin
         nsob = 0;
         for (int k = 0; k < 64; k++) begin
            total++;
            if (obs_val[k] !== DW'(exp_val(0, k))) begin
               bad++; $display("FAIL ramp_data k=%0d got=%0d want=%0d", k, obs_val[k], exp_val(0, k));
            end
            nsob += int'(obs_sob[k]);
         end
         total++;
         if (nsob != 1 || obs_sob[0] !== 1'b1) begin
            bad++; $display("FAIL ramp_sob got count=%0d first=%b want count=1 first=1", nsob, obs_sob[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int gaps;
      int nsob;
      int base;
      gaps = 0;
      do_reset();
      for (int i = 0; i < 192; i++) begin
         cyc(1'b1, in_val(100 * (i / 64), i % 64));
         if (i >= 64 && valid_out !== 1'b1) gaps++;
      end
      cyc(1'b0, 0);
      total++;
      if (gaps != 0) begin
         bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps);
      end
      total++;
      if (obs_val.size() != 128) begin
         bad++; $display("FAIL b2b_count got=%0d want=128", obs_val.size());
      end else begin
         nsob = 0;
         for (int k = 0; k < 128; k++) begin
            base = 100 * (k / 64);
            total++;
            if (obs_val[k] !== DW'(exp_val(base, k % 64))) begin
               bad++; $display("FAIL b2b_data k=%0d got=%0d want=%0d", k, obs_val[k], exp_val(base, k % 64));
            end
            nsob += int'(obs_sob[k]);
         end
         total++;
         if (nsob != 2 || obs_sob[0] !== 1'b1 || obs_sob[64] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_sob got count=%0d s0=%b s64=%b want count=2 s0=1 s64=1",
                     nsob, obs_sob[0], obs_sob[64]);
         end
      end
   endtask

   task automatic test_random_stall();
      int acc;
      int cycles;
      int nsob;
      int base;
      bit e;
      acc = 0;
      cycles = 0;
      do_reset();
      while (acc < 256 && cycles < 4000) begin
         e = 1'($urandom_range(0, 1));
         cyc(e, in_val(300 * (acc / 64), acc % 64));
         if (e) acc++;
         cycles++;
      end
      cyc(1'b0, 0);
      total++;
      if (acc != 256) begin
         bad++; $display("FAIL rand_timeout got=%0d samples want=256", acc);
      end
      total++;
      if (stray != 0) begin
         bad++; $display("FAIL rand_stray_valid got=%0d want=0", stray);
      end
      total++;
      if (obs_val.size() != 192) begin
         bad++; $display("FAIL rand_count got=%0d want=192", obs_val.size());
      end else begin
         nsob = 0;
         for (int k = 0; k < 192; k++) begin
            base = 300 * (k / 64);
            total++;
            if (obs_val[k] !== DW'(exp_val(base, k % 64))) begin
               bad++; $display("FAIL rand_data k=%0d got=%0d want=%0d", k, obs_val[k], exp_val(base, k % 64));
            end
            nsob += int'(obs_sob[k]);
         end
         total++;
         if (nsob != 3) begin
            bad++; $display("FAIL rand_sob got=%0d want=3", nsob);
         end
      end
   endtask

   task automatic test_reset_mid();
      int early;
      int nsob;
      early = 0;
      do_reset();
      for (int i = 0; i < 94; i++) begin
         cyc(1'b1, (i < 64) ? in_val(700, i) : in_val(800, i - 64));
      end
      rst = 1'b1;
      cyc(1'b1, 5);
      rst = 1'b0;
      obs_val.delete();
      obs_sob.delete();
      stray = 0;
      total++;
      if (valid_out !== 1'b0) begin
         bad++; $display("FAIL rstmid_valid got=%b want=0", valid_out);
      end
      for (int i = 0; i < 128; i++) begin
         cyc(1'b1, (i < 64) ? in_val(0, i) : in_val(100, i - 64));
         if (i < 64 && valid_out !== 1'b0) early++;
      end
      cyc(1'b0, 0);
      total++;
      if (early != 0) begin
         bad++; $display("FAIL rstmid_early_valid got=%0d want=0", early);
      end
      total++;
      if (obs_val.size() != 64) begin
         bad++; $display("FAIL rstmid_count got=%0d want=64", obs_val.size());
      end else begin
         nsob = 0;
         for (int k = 0; k < 64; k++) begin
            total++;
            if (obs_val[k] !== DW'(exp_val(0, k))) begin
               bad++; $display("FAIL rstmid_data k=%0d got=%0d want=%0d", k, obs_val[k], exp_val(0, k));
            end
            nsob += int'(obs_sob[k]);
         end
         total++;
         if (nsob != 1 || obs_sob[0] !== 1'b1) begin
            bad++; $display("FAIL rstmid_sob got count=%0d first=%b want count=1 first=1", nsob, obs_sob[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_back_to_back();
      test_random_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
